// File: rtl/muldiv_pkg.sv
// Shared encodings and width defaults for the iterative multiply/divide unit.
// Imported by the step datapath and the top-level sequencer.
package muldiv_pkg;

  localparam int DATA_LEN_DEF = 32;
  localparam int ADDR_LEN_DEF = 4;

  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_MULHU = 2'd1,
    OP_DIVU  = 2'd2,
    OP_REMU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Purely combinational; the top level registers the accumulators.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                is_div,
  input  logic [DATA_LEN:0]   acc_hi,
  input  logic [DATA_LEN-1:0] acc_lo,
  input  logic [DATA_LEN-1:0] operand,
  output logic [DATA_LEN:0]   nxt_hi,
  output logic [DATA_LEN-1:0] nxt_lo
);

  logic [DATA_LEN:0] addend;
  logic [DATA_LEN:0] sum;
  logic [DATA_LEN:0] rem_sh;
  logic [DATA_LEN:0] divisor;
  logic [DATA_LEN:0] diff;

  always_comb begin
    addend  = acc_lo[0] ? {1'b0, operand} : '0;
    sum     = acc_hi + addend;
    rem_sh  = {acc_hi[DATA_LEN-1:0], acc_lo[DATA_LEN-1]};
    divisor = {1'b0, operand};
    diff    = rem_sh - divisor;
    nxt_hi  = '0;
    nxt_lo  = '0;
    if (is_div) begin
      if (rem_sh >= divisor) begin
        nxt_hi = diff;
        nxt_lo = {acc_lo[DATA_LEN-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh;
        nxt_lo = {acc_lo[DATA_LEN-2:0], 1'b0};
      end
    end else begin
      // carry lands in hi; lsb of sum drops into lo
      nxt_hi = {1'b0, sum[DATA_LEN:1]};
      nxt_lo = {sum[0], acc_lo[DATA_LEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU with start/busy handshake.
// One bit per cycle; result written back through rd/wrt_en/wrt_data.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [ADDR_LEN-1:0] rd_in,
  input  logic [DATA_LEN-1:0] src1,
  input  logic [DATA_LEN-1:0] src2,
  output logic                busy,
  output logic                wrt_en,
  output logic [ADDR_LEN-1:0] rd,
  output logic [DATA_LEN-1:0] wrt_data
);

  localparam int CW = $clog2(DATA_LEN);
  localparam logic [CW-1:0] LAST = CW'(DATA_LEN - 1);

  state_e              state;
  op_e                 op_q;
  logic [CW-1:0]       cnt;
  logic [ADDR_LEN-1:0] rd_q;
  logic [DATA_LEN-1:0] opd;
  logic [DATA_LEN:0]   hi;
  logic [DATA_LEN-1:0] lo;
  logic [DATA_LEN:0]   nxt_hi;
  logic [DATA_LEN-1:0] nxt_lo;
  logic [DATA_LEN-1:0] res;

  muldiv_step #(.DATA_LEN(DATA_LEN)) u_step (
    .is_div  (op_q[1]),
    .acc_hi  (hi),
    .acc_lo  (lo),
    .operand (opd),
    .nxt_hi  (nxt_hi),
    .nxt_lo  (nxt_lo)
  );

  // result taken from the final iteration's next values
  always_comb begin
    res = '0;
    unique case (op_q)
      OP_MUL:   res = nxt_lo;
      OP_MULHU: res = nxt_hi[DATA_LEN-1:0];
      OP_DIVU:  res = nxt_lo;
      OP_REMU:  res = nxt_hi[DATA_LEN-1:0];
      default:  res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      cnt      <= '0;
      rd_q     <= '0;
      opd      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      wrt_en   <= 1'b0;
      rd       <= '0;
      wrt_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op_e'(op);
            rd_q  <= rd_in;
            cnt   <= '0;
            hi    <= '0;
            lo    <= op[1] ? src1 : src2;
            opd   <= op[1] ? src2 : src1;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= WB;
            wrt_en   <= 1'b1;
            rd       <= rd_q;
            wrt_data <= res;
          end
        end
        WB: begin
          wrt_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written
// sequences for ignored start, held start, and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [3:0]  rd_in = 4'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        busy;
  logic        wrt_en;
  logic [3:0]  rd;
  logic [31:0] wrt_data;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rd_in    (rd_in),
    .src1     (src1),
    .src2     (src2),
    .busy     (busy),
    .wrt_en   (wrt_en),
    .rd       (rd),
    .wrt_data (wrt_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called just after a clock edge with the unit idle.
  // mode 1: junk start pulse during RUN; mode 2: operands change after accept.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] r,
                        input logic [31:0] exp, input int mode,
                        input string tag);
    int lat;
    int bc;
    int wc;
    logic [3:0]  rdv;
    logic [31:0] dv;
    lat = 0; bc = 0; wc = 0; rdv = 4'd0; dv = 32'd0;
    op = o; src1 = a; src2 = b; rd_in = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (mode == 2) begin
      src1 = ~a; src2 = b + 32'd1; op = ~o; rd_in = ~r;
    end
    for (int n = 1; n <= 36; n++) begin
      if (busy) bc++;
      if (wrt_en) begin
        wc++;
        if (lat == 0) begin
          lat = n; rdv = rd; dv = wrt_data;
        end
      end
      if (mode == 1 && n == 5) begin
        start = 1'b1; op = OP_MUL; src1 = 32'd999; src2 = 32'd3;
        rd_in = r + 4'd1;
      end
      if (mode == 1 && n == 6) start = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, " data"}, dv, exp);
    chk({tag, " rd"}, 32'(rdv), 32'(r));
    chk({tag, " latency"}, 32'(lat), 32'd33);
    chk({tag, " busy_cycles"}, 32'(bc), 32'd33);
    chk({tag, " wrt_en_pulses"}, 32'(wc), 32'd1);
  endtask

  initial begin
    int prev;
    int pulses;
    int wc;

    vecs[0]  = '{OP_MUL,   32'd7,          32'd6,          4'd3,  32'd42,         "mul_7x6"};
    vecs[1]  = '{OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd4,  32'hFFFF_FFFE,  "mulhu_max"};
    vecs[2]  = '{OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd5,  32'h0000_0001,  "mul_max"};
    vecs[3]  = '{OP_DIVU,  32'd100,        32'd7,          4'd6,  32'd14,         "divu_100_7"};
    vecs[4]  = '{OP_REMU,  32'd100,        32'd7,          4'd7,  32'd2,          "remu_100_7"};
    vecs[5]  = '{OP_DIVU,  32'd5,          32'd0,          4'd8,  32'hFFFF_FFFF,  "divu_by0"};
    vecs[6]  = '{OP_REMU,  32'd5,          32'd0,          4'd9,  32'd5,          "remu_by0"};
    vecs[7]  = '{OP_MULHU, 32'h8000_0000,  32'd4,          4'd10, 32'd2,          "mulhu_shift"};
    vecs[8]  = '{OP_MUL,   32'h1234_5678,  32'h10,         4'd11, 32'h2345_6780,  "mul_wrap"};
    vecs[9]  = '{OP_DIVU,  32'hFFFF_FFFF,  32'd1,          4'd12, 32'hFFFF_FFFF,  "divu_by1"};
    vecs[10] = '{OP_REMU,  32'hFFFF_FFFF,  32'h10,         4'd15, 32'hF,          "remu_max"};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset wrt_en", 32'(wrt_en), 32'd0);
    chk("reset rd", 32'(rd), 32'd0);
    chk("reset wrt_data", wrt_data, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, 0, vecs[i].name);

    run_op(OP_DIVU, 32'd100, 32'd7, 4'd2, 32'd14, 1, "start_in_run");
    run_op(OP_MUL, 32'd1000, 32'd1000, 4'd13, 32'd1000000, 2, "opnd_change");

    // start held high: one accept every 34 cycles
    op = OP_MUL; src1 = 32'd3; src2 = 32'd5; rd_in = 4'd7; start = 1'b1;
    prev = 0; pulses = 0;
    for (int n = 1; n <= 110; n++) begin
      @(posedge clk); #1;
      if (wrt_en) begin
        pulses++;
        chk("hold data", wrt_data, 32'd15);
        if (prev != 0) chk("hold interval", 32'(n - prev), 32'd34);
        prev = n;
      end
    end
    start = 1'b0;
    chk("hold pulses", 32'(pulses), 32'd3);
    repeat (40) @(posedge clk);
    #1;

    // reset at cycle 10 of a DIVU
    op = OP_DIVU; src1 = 32'd100; src2 = 32'd7; rd_in = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort wrt_en", 32'(wrt_en), 32'd0);
    chk("abort rd", 32'(rd), 32'd0);
    chk("abort wrt_data", wrt_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wc = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (wrt_en) wc++;
    end
    chk("abort no_wrt_en", 32'(wc), 32'd0);
    run_op(OP_MUL, 32'd3, 32'd3, 4'd5, 32'd9, 0, "after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit for the processor's execute stage. It consumes the two register-file read operands and writes its result back through the register-file write port (`rd`/`wrt_en`/`wrt_data`). It uses a start/busy handshake so the controller stalls issue while an operation is in flight. The datapath is shift-add for multiply and restoring division for divide, with one bit per cycle.

## Interface
- `DATA_LEN`, 32: operand and result width.
- `ADDR_LEN`, 4: destination register index width.
- `clk` input 1: single clock. All state changes on its rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the `clk` rising edge; 0 resets.
- `start` input 1: request a new operation. Accepted only in IDLE.
- `op` input 2: operation select.
  - 0 MUL: low half of the product.
  - 1 MULHU: high half of the product.
  - 2 DIVU: quotient.
  - 3 REMU: remainder.
- `rd_in` input ADDR_LEN: destination register, latched on accept.
- `src1` input DATA_LEN: multiplicand or dividend (register-file out1).
- `src2` input DATA_LEN: multiplier or divisor (register-file out2).
- `busy` output 1: high from the cycle after accept through the writeback cycle.
- `wrt_en` output 1: one-cycle writeback strobe to the register file.
- `rd` output ADDR_LEN: writeback destination register.
- `wrt_data` output DATA_LEN: writeback result.

## Operation
- Three states: IDLE, RUN, WB.
  - IDLE -> RUN when `start`=1.
  - RUN -> WB when the iteration counter reaches DATA_LEN-1.
  - WB -> IDLE unconditionally.
- On accept:
  - Latch `op`, `rd_in`, `src1`, `src2`.
  - Clear the counter.
  - For MUL/MULHU: hi accumulator (DATA_LEN+1 bits) = 0, lo = `src2`.
  - For DIVU/REMU: remainder (DATA_LEN+1 bits) = 0, quotient = `src1`.
- Multiply step:
  - If lo[0]=1, hi = hi + multiplicand, computed with a carry bit.
  - Then {hi,lo} is shifted right by 1.
- Divide step:
  - r' = {r[DATA_LEN-1:0], q[DATA_LEN-1]}.
  - If r' >= divisor: r = r' - divisor, shift 1 into q.
  - Otherwise: r = r', shift 0 into q.
- Divide by zero needs no special case. It naturally yields quotient = all ones and remainder = `src1`.
- All arithmetic is unsigned and modulo 2^DATA_LEN on the outputs. The MULHU result is exact.
- In WB:
  - `wrt_en`=1, `rd` = latched `rd_in`.
  - `wrt_data` = lo / hi[DATA_LEN-1:0] / quotient / remainder, selected by the latched `op`.
- `start` while `busy`=1 is ignored. No queueing; the caller must hold issue.
- Source or destination register index 0 is not special-cased here.

## Timing
- Reset values: `busy`=0, `wrt_en`=0, `rd`=0, `wrt_data`=0, state IDLE, counter 0.
- Reset asserted mid-operation:
  - Return to IDLE on that edge.
  - No `wrt_en` is produced for the aborted operation.
  - All outputs return to their reset values.
- `start` is accepted at edge T. Then:
  - RUN occupies cycles T+1 … T+DATA_LEN, i.e. DATA_LEN iterations.
  - WB occurs in cycle T+DATA_LEN+1.
- Latency from accept to `wrt_en` is DATA_LEN+1 cycles, fixed for every op including divide by zero.
- `busy`=1 in RUN and WB. The earliest next accept is the edge ending WB+1, back in IDLE.
- Throughput is one operation per DATA_LEN+2 cycles.
- All outputs are registered. `wrt_en` is high for exactly one cycle per accepted operation.
- Operand inputs may change freely after accept; only latched copies are used.

## Structure
- Shared package holds:
  - op encodings: OP_MUL=0, OP_MULHU=1, OP_DIVU=2, OP_REMU=3.
  - state encodings: IDLE, RUN, WB.
  - width defaults for DATA_LEN and ADDR_LEN.
- One sub-module, `muldiv_step`: the combinational single-iteration datapath.
  - Inputs: op class, acc_hi, acc_lo, operand.
  - Outputs: next acc_hi, next acc_lo.
- The top level holds the FSM, counter, operand and rd latches, and output registers.

## Test plan
- MUL 7 × 6, `rd_in`=3: `wrt_en` pulses exactly 33 cycles after accept, `rd`=3, `wrt_data`=42; `busy` high for 33 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF: `wrt_data`=0xFFFFFFFE. The same operands with MUL give 0x00000001.
- DIVU 100 / 7 gives 14; REMU 100 / 7 gives 2. DIVU 5 / 0 gives 0xFFFFFFFF; REMU 5 / 0 gives 5.
- `start` pulsed during RUN with different operands: ignored, result unchanged. `start` held high continuously: operations accepted every 34 cycles.
- Reset driven low at cycle 10 of a DIVU: outputs 0 on the next edge and no `wrt_en` ever appears. A new MUL 3 × 3 issued after release returns 9.
- Operands changed on the cycle after accept: the result reflects the originally latched values.
